// File: rtl/ssd1289_bus_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | ssd1289_bus_pkg: shared word format, engine state and owner encodings    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package ssd1289_bus_pkg;

  localparam int LCD_WORD_W = 17;
  localparam int LCD_RS_BIT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    WR_LOW  = 2'd2,
    WR_HIGH = 2'd3
  } eng_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    INIT = 2'd1,
    PLOT = 2'd2
  } owner_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ssd1289_bus_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | ssd1289_bus_arbiter_if: requester handshakes and LCD write-bus pins      |
// | Optional ARB_STATS_EN adds stat_words/stat_drops.  Rev 1.0               |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ssd1289_bus_arbiter_if;
  import ssd1289_bus_pkg::*;

  logic                  init_valid;
  logic                  init_ready;
  logic [LCD_WORD_W-1:0] init_dout;
  logic                  init_done;
  logic                  plot_valid;
  logic [LCD_WORD_W-1:0] plot_dout;
  logic                  plot_ovf;
  logic                  lcd_cs_n;
  logic                  lcd_rs;
  logic                  lcd_wr_n;
  logic                  lcd_rd_n;
  logic [15:0]           lcd_db;
  logic                  bus_idle;
`ifdef ARB_STATS_EN
  logic [31:0]           stat_words;
  logic [15:0]           stat_drops;

  modport master (
    output init_valid, init_dout, init_done, plot_valid, plot_dout,
    input  init_ready, plot_ovf, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_db,
    input  bus_idle, stat_words, stat_drops
  );
  modport slave (
    input  init_valid, init_dout, init_done, plot_valid, plot_dout,
    output init_ready, plot_ovf, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_db,
    output bus_idle, stat_words, stat_drops
  );
`else
  modport master (
    output init_valid, init_dout, init_done, plot_valid, plot_dout,
    input  init_ready, plot_ovf, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_db,
    input  bus_idle
  );
  modport slave (
    input  init_valid, init_dout, init_done, plot_valid, plot_dout,
    output init_ready, plot_ovf, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_db,
    output bus_idle
  );
`endif

endinterface

`default_nettype wire

// File: rtl/ssd1289_bus_arbiter_fifo.sv
// +--------------------------------------------------------------------------+
// | lcd_word_fifo: synchronous show-ahead FIFO with simultaneous push/pop    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module lcd_word_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/ssd1289_bus_arbiter.sv
// +--------------------------------------------------------------------------+
// | ssd1289_bus_arbiter: shares the SSD1289 8080 write bus between the init  |
// | sequencer and the buffered plot stream.  Optional macro: ARB_STATS_EN.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ssd1289_bus_arbiter
  import ssd1289_bus_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SETUP_CYC   = 1,
  parameter int WR_LOW_CYC  = 1,
  parameter int WR_HIGH_CYC = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  ssd1289_bus_arbiter_if.slave bus
);

  localparam int MAX_CYC = max3(SETUP_CYC, WR_LOW_CYC, WR_HIGH_CYC);
  localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  eng_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic                  cs_n_q, wr_n_q, rs_q, ovf_q, idle_q;
  logic [15:0]           db_q;

  logic [LCD_WORD_W-1:0] fifo_rdata, word;
  logic                  fifo_full, fifo_empty, fifo_push;
  logic                  ph_last, fetch, take_init, take_plot, take_any;
  logic                  plot_ok, plot_drop;

  assign plot_ok   = bus.plot_valid & bus.init_done;
  assign fifo_push = plot_ok & (~fifo_full | take_plot);
  assign plot_drop = plot_ok & fifo_full & ~take_plot;

  lcd_word_fifo #(
    .WIDTH (LCD_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (bus.plot_dout),
    .pop_i   (take_plot),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    ph_last = 1'b0;
    unique case (state_q)
      SETUP:   ph_last = (phase_q == PH_W'(SETUP_CYC - 1));
      WR_LOW:  ph_last = (phase_q == PH_W'(WR_LOW_CYC - 1));
      WR_HIGH: ph_last = (phase_q == PH_W'(WR_HIGH_CYC - 1));
      default: ph_last = 1'b0;
    endcase
  end

  // A pending plot parameter wins over init while the plot path holds the lock.
  assign fetch     = (state_q == IDLE) | ((state_q == WR_HIGH) & ph_last);
  assign take_init = fetch & bus.init_valid & ~((owner_q == PLOT) & ~fifo_empty);
  assign take_plot = fetch & ~fifo_empty & ~take_init;
  assign take_any  = take_init | take_plot;
  assign word      = take_init ? bus.init_dout : fifo_rdata;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    phase_d = phase_q + PH_W'(1);
    unique case (state_q)
      IDLE:    if (take_any) state_d = SETUP;
      SETUP:   if (ph_last)  state_d = WR_LOW;
      WR_LOW:  if (ph_last)  state_d = WR_HIGH;
      WR_HIGH: if (ph_last)  state_d = take_any ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
    if (take_init) begin
      owner_d = word[LCD_RS_BIT] ? NONE : INIT;
    end else if (take_plot) begin
      owner_d = word[LCD_RS_BIT] ? NONE : PLOT;
    end
    if ((state_d != state_q) || (state_q == IDLE)) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= NONE;
      phase_q <= '0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      rs_q    <= 1'b0;
      db_q    <= '0;
      ovf_q   <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      phase_q <= phase_d;
      cs_n_q  <= (state_d == IDLE);
      wr_n_q  <= (state_d != WR_LOW);
      if (take_any) begin
        rs_q <= word[LCD_RS_BIT];
        db_q <= word[15:0];
      end
      if (plot_drop) ovf_q <= 1'b1;
      idle_q  <= (state_q == IDLE) & fifo_empty & ~bus.init_valid;
    end
  end

  assign bus.init_ready = take_init & ~rst;
  assign bus.plot_ovf   = ovf_q;
  assign bus.lcd_cs_n   = cs_n_q;
  assign bus.lcd_wr_n   = wr_n_q;
  assign bus.lcd_rd_n   = 1'b1;
  assign bus.lcd_rs     = rs_q;
  assign bus.lcd_db     = db_q;
  assign bus.bus_idle   = idle_q;

`ifdef ARB_STATS_EN
  logic [31:0] words_q;
  logic [15:0] drops_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      words_q <= '0;
      drops_q <= '0;
    end else begin
      if ((state_q == WR_LOW) && ph_last) words_q <= words_q + 32'd1;
      if (plot_drop && (drops_q != 16'hFFFF)) drops_q <= drops_q + 16'd1;
    end
  end

  assign bus.stat_words = words_q;
  assign bus.stat_drops = drops_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ssd1289_bus_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_ssd1289_bus_arbiter: scoreboard bench for the SSD1289 bus arbiter     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ssd1289_bus_arbiter;
  import ssd1289_bus_pkg::*;

  typedef struct {
    logic [LCD_WORD_W-1:0] w;
    int                    fall;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q1[$];
  exp_t q2[$];
  int   drops [11] = '{24, 26, 27, 29, 30, 32, 33, 35, 36, 38, 39};

  ssd1289_bus_arbiter_if b1 ();
  ssd1289_bus_arbiter_if b2 ();

  ssd1289_bus_arbiter u_dut1 (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (b1)
  );

  ssd1289_bus_arbiter #(
    .SETUP_CYC   (2),
    .WR_LOW_CYC  (3),
    .WR_HIGH_CYC (1)
  ) u_dut2 (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (b2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_step(input int id, input logic wr_n, input logic cs_n,
                          input logic [LCD_WORD_W-1:0] w, input int low_exp,
                          inout logic prev, inout int low);
    exp_t e;
    int   qs;
    if (prev && !wr_n) begin
      chk($sformatf("m%0d_cs_n", id), 32'(cs_n), 32'd0);
      qs = (id == 1) ? q1.size() : q2.size();
      if (qs == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL m%0d_unexpected_write: got %h required none", id, w);
      end else begin
        if (id == 1) e = q1.pop_front();
        else         e = q2.pop_front();
        chk($sformatf("m%0d_word", id), 32'(w), 32'(e.w));
        if (e.fall >= 0) chk($sformatf("m%0d_fall_cycle", id), cyc, e.fall);
      end
    end
    if (!wr_n) low++;
    else if (!prev) begin
      chk($sformatf("m%0d_wr_low_width", id), low, low_exp);
      low = 0;
    end
    prev = wr_n;
  endtask

  initial begin : mon1
    logic prev1;
    int   low1;
    prev1 = 1'b1;
    low1  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev1 = 1'b1;
        low1  = 0;
      end else mon_step(1, b1.lcd_wr_n, b1.lcd_cs_n, {b1.lcd_rs, b1.lcd_db}, 1, prev1, low1);
    end
  end

  initial begin : mon2
    logic prev2;
    int   low2;
    prev2 = 1'b1;
    low2  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev2 = 1'b1;
        low2  = 0;
      end else mon_step(2, b2.lcd_wr_n, b2.lcd_cs_n, {b2.lcd_rs, b2.lcd_db}, 3, prev2, low2);
    end
  end

  task automatic wait_idle1(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b1.bus_idle && n < 400);
    if (!b1.bus_idle) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_idle_timeout: got bus_idle=0 required 1", tag);
    end
  endtask

  // Accepted word is expected on the bus 2 cycles later (SETUP_CYC=1).
  task automatic send_init(input logic [LCD_WORD_W-1:0] w, output int t);
    int n = 0;
    b1.init_dout  = w;
    b1.init_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!b1.init_ready && n < 50);
    t = cyc;
    if (!b1.init_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL init_ready_timeout: got 0 required 1");
    end else q1.push_back('{w, cyc + 2});
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_drop(input int k);
    for (int i = 0; i < 11; i++) if (drops[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, t1, s, n;
    logic [LCD_WORD_W-1:0] w;
    b1.init_valid = 1'b0; b1.init_dout = '0; b1.init_done = 1'b0;
    b1.plot_valid = 1'b0; b1.plot_dout = '0;
    b2.init_valid = 1'b0; b2.init_dout = '0; b2.init_done = 1'b1;
    b2.plot_valid = 1'b0; b2.plot_dout = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(b1.lcd_cs_n), 32'd1);
    chk("rst_wr_n", 32'(b1.lcd_wr_n), 32'd1);
    chk("rst_rd_n", 32'(b1.lcd_rd_n), 32'd1);
    chk("rst_rs", 32'(b1.lcd_rs), 32'd0);
    chk("rst_db", 32'(b1.lcd_db), 32'd0);
    chk("rst_init_ready", 32'(b1.init_ready), 32'd0);
    chk("rst_ovf", 32'(b1.plot_ovf), 32'd0);
    chk("rst_bus_idle", 32'(b1.bus_idle), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Held-valid init pair: one word per 3-cycle slot, cs_n stays low between.
    send_init(17'h00044, t0);
    send_init(17'h1EF00, t1);
    b1.init_valid = 1'b0;
    chk("init_spacing", t1 - t0, 3);
    repeat (3) begin
      @(negedge clk);
      chk("init_cs_n_held", 32'(b1.lcd_cs_n), 32'd0);
    end
    @(negedge clk);
    chk("init_cs_n_release", 32'(b1.lcd_cs_n), 32'd1);

    // Plot words before init_done are discarded silently.
    wait_idle1("pre_done");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      b1.plot_valid = 1'b1;
      b1.plot_dout  = 17'h10000 | 17'(k);
    end
    @(posedge clk);
    #1;
    b1.plot_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_done_idle", 32'(b1.bus_idle), 32'd1);
    chk("pre_done_ovf", 32'(b1.plot_ovf), 32'd0);

    // 40-word burst into a 16-deep FIFO draining one word per 3 cycles.
    b1.init_done = 1'b1;
    wait_idle1("burst_start");
    @(posedge clk);
    #1;
    for (int k = 0; k < 40; k++) begin
      w = {1'(k % 2), 16'h1000 + 16'(k)};
      b1.plot_valid = 1'b1;
      b1.plot_dout  = w;
      if (!is_drop(k)) q1.push_back('{w, -1});
      if (k == 16) chk("burst_no_ovf_at_17", 32'(b1.plot_ovf), 32'd0);
      @(posedge clk);
      #1;
    end
    b1.plot_valid = 1'b0;
    wait_idle1("burst_drain");
    chk("burst_ovf", 32'(b1.plot_ovf), 32'd1);
    chk("burst_sb_empty", q1.size(), 32'd0);
`ifdef ARB_STATS_EN
    chk("stat_words", b1.stat_words, 32'd31);
    chk("stat_drops", 32'(b1.stat_drops), 32'd11);
`endif

    // Plot command/parameter pair must not be split by a waiting init word.
    wait_idle1("owner_start");
    @(posedge clk);
    #1;
    s = cyc;
    b1.plot_valid = 1'b1;
    b1.plot_dout  = 17'h00022;
    q1.push_back('{17'h00022, s + 3});
    @(posedge clk);
    #1;
    b1.plot_dout  = 17'h11234;
    q1.push_back('{17'h11234, s + 6});
    @(posedge clk);
    #1;
    b1.plot_valid = 1'b0;
    send_init(17'h00044, t0);
    b1.init_valid = 1'b0;
    chk("owner_init_slot", t0 - s, 7);

    // Reset while wr_n is low aborts the write and flushes queued words.
    wait_idle1("rst_start");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      b1.plot_valid = 1'b1;
      b1.plot_dout  = 17'h10A00 | 17'(k);
      if (k == 0) q1.push_back('{17'h10A00, -1});
    end
    @(posedge clk);
    #1;
    b1.plot_valid = 1'b0;
    n = 0;
    while (b1.lcd_wr_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_wr_low", 32'(b1.lcd_wr_n), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("abort_cs_n", 32'(b1.lcd_cs_n), 32'd1);
    chk("abort_wr_n", 32'(b1.lcd_wr_n), 32'd1);
    chk("abort_bus_idle", 32'(b1.bus_idle), 32'd1);
    q1.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_idle", 32'(b1.bus_idle), 32'd1);
    chk("post_rst_ovf", 32'(b1.plot_ovf), 32'd0);
    chk("post_rst_cs_n", 32'(b1.lcd_cs_n), 32'd1);

    // Stretched timing on the second instance: 2+3+1 = 6-cycle word period.
    @(posedge clk);
    #1;
    s = cyc;
    for (int k = 0; k < 3; k++) begin
      w = {1'b1, 16'hC000 + 16'(k)};
      b2.plot_valid = 1'b1;
      b2.plot_dout  = w;
      q2.push_back('{w, s + 4 + 6 * k});
      @(posedge clk);
      #1;
    end
    b2.plot_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b2.bus_idle && n < 200);
    chk("period_idle", 32'(b2.bus_idle), 32'd1);
    chk("period_sb_empty", q2.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
